regfile: RTL and testbench

Architectural register file with rename-tag tracking for the Tomasulo core. It sits between the dispatcher/RS, which reads operands and renames destinations at issue, and the ROB, which retires results in program order via its commit port. It is the consumer end of the ROB commit interface. It also holds the per-register "busy + ROB tag" state that tells the RS whether an operand is ready or must wait on a ROB entry. A ROB mispredict flush clears all pending renames.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_read_port.sv | 53 +++++
 rtl/regfile.sv | 103 ++++++++++
 tb/tb_regfile.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, types and helpers for the architectural
//               register file with rename-tag tracking.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Architectural register index width and register count
    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;

    // Default widths shared with the ROB / RS / LSB
    localparam int ROB_IDX_W_DEFAULT = 4;
    localparam int XLEN_DEFAULT      = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // x0 is hardwired; only nonzero indices name real storage
    function automatic logic is_arch_reg(input reg_idx_t idx);
        return (idx != '0);
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_read_port
// Description : Combinational operand lookup with same-cycle commit bypass.
//               Returns busy/tag/value for one source index.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_IDX_W_DEFAULT,
    parameter int XLEN      = XLEN_DEFAULT
) (
    input  logic [REG_IDX_W-1:0] i_rs_index,
    input  logic [NUM_REGS-1:0]  i_busy_vec,
    input  logic [ROB_IDX_W-1:0] i_tag_arr   [NUM_REGS],
    input  logic [XLEN-1:0]      i_value_arr [NUM_REGS],
    input  logic                 i_commit_en,
    input  logic [REG_IDX_W-1:0] i_commit_rd,
    input  logic [ROB_IDX_W-1:0] i_commit_tag,
    input  logic [XLEN-1:0]      i_commit_value,
    output logic                 o_rs_busy,
    output logic [ROB_IDX_W-1:0] o_rs_tag,
    output logic [XLEN-1:0]      o_rs_value
);

    logic w_hit;

    // Lookup stored state; a retiring producer of this operand is forwarded
    always_comb begin
        w_hit = i_commit_en
             && is_arch_reg(i_rs_index)
             && (i_commit_rd == i_rs_index)
             && i_busy_vec[i_rs_index]
             && (i_tag_arr[i_rs_index] == i_commit_tag);

        o_rs_busy  = 1'b0;
        o_rs_tag   = '0;
        o_rs_value = '0;
        if (is_arch_reg(i_rs_index)) begin
            o_rs_tag = i_tag_arr[i_rs_index];
            if (w_hit) begin
                o_rs_busy  = 1'b0;
                o_rs_value = i_commit_value;
            end else begin
                o_rs_busy  = i_busy_vec[i_rs_index];
                o_rs_value = i_value_arr[i_rs_index];
            end
        end
    end

endmodule : regfile_read_port
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
// Module      : regfile
// Description : Architectural register file with per-register busy + ROB tag
//               rename state. Renamed at issue, retired by the ROB commit
//               port, renames discarded on mispredict flush.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile
    import regfile_pkg::*;
#(
    parameter int ROB_IDX_W = ROB_IDX_W_DEFAULT,
    parameter int XLEN      = XLEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 issue_en,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_IDX_W-1:0] issue_tag,
    input  logic [REG_IDX_W-1:0] rs1_index,
    input  logic [REG_IDX_W-1:0] rs2_index,
    output logic                 rs1_busy,
    output logic                 rs2_busy,
    output logic [ROB_IDX_W-1:0] rs1_tag,
    output logic [ROB_IDX_W-1:0] rs2_tag,
    output logic [XLEN-1:0]      rs1_value,
    output logic [XLEN-1:0]      rs2_value,
    input  logic                 commit_en,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_IDX_W-1:0] commit_tag,
    input  logic [XLEN-1:0]      commit_value,
    input  logic                 flush
);

    logic [XLEN-1:0]      r_value [NUM_REGS];
    logic [ROB_IDX_W-1:0] r_tag   [NUM_REGS];
    logic [NUM_REGS-1:0]  r_busy;

    // Register state update; issue is applied last so it wins on busy/tag.
    // Entry 0 is only ever touched by reset, so it stays all-zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
            r_busy <= '0;
        end else if (rdy) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (commit_en && (commit_rd == REG_IDX_W'(i))) begin
                    r_value[i] <= commit_value;
                    if (r_busy[i] && (r_tag[i] == commit_tag)) begin
                        r_busy[i] <= 1'b0;
                    end
                end
                if (flush) begin
                    r_busy[i] <= 1'b0;
                end
                if (issue_en && !flush && (issue_rd == REG_IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                    r_tag[i]  <= issue_tag;
                end
            end
        end
    end

    regfile_read_port #(
        .ROB_IDX_W (ROB_IDX_W),
        .XLEN      (XLEN)
    ) u_rs1_port (
        .i_rs_index     (rs1_index),
        .i_busy_vec     (r_busy),
        .i_tag_arr      (r_tag),
        .i_value_arr    (r_value),
        .i_commit_en    (commit_en),
        .i_commit_rd    (commit_rd),
        .i_commit_tag   (commit_tag),
        .i_commit_value (commit_value),
        .o_rs_busy      (rs1_busy),
        .o_rs_tag       (rs1_tag),
        .o_rs_value     (rs1_value)
    );

    regfile_read_port #(
        .ROB_IDX_W (ROB_IDX_W),
        .XLEN      (XLEN)
    ) u_rs2_port (
        .i_rs_index     (rs2_index),
        .i_busy_vec     (r_busy),
        .i_tag_arr      (r_tag),
        .i_value_arr    (r_value),
        .i_commit_en    (commit_en),
        .i_commit_rd    (commit_rd),
        .i_commit_tag   (commit_tag),
        .i_commit_value (commit_value),
        .o_rs_busy      (rs2_busy),
        .o_rs_tag       (rs2_tag),
        .o_rs_value     (rs2_value)
    );

endmodule : regfile
`default_nettype wire

// File: tb/tb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile
// Description : Directed self-checking bench for regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [3:0]  issue_tag;
    logic [4:0]  rs1_index;
    logic [4:0]  rs2_index;
    logic        rs1_busy;
    logic        rs2_busy;
    logic [3:0]  rs1_tag;
    logic [3:0]  rs2_tag;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic        commit_en;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_tag;
    logic [31:0] commit_value;
    logic        flush;

    int n_checks;
    int n_fail;

    regfile #(
        .ROB_IDX_W (4),
        .XLEN      (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .issue_en     (issue_en),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .rs1_index    (rs1_index),
        .rs2_index    (rs2_index),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rs1_value    (rs1_value),
        .rs2_value    (rs2_value),
        .commit_en    (commit_en),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_value (commit_value),
        .flush        (flush)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Read idx on both ports; exp_tag < 0 means tag is don't-care
    task automatic read_reg(input string name, input logic [4:0] idx,
                            input logic exp_busy, input int exp_tag,
                            input logic [31:0] exp_val);
        rs1_index = idx;
        rs2_index = idx;
        #1;
        check({name, ".rs1_busy"},  {31'd0, rs1_busy}, {31'd0, exp_busy});
        check({name, ".rs2_busy"},  {31'd0, rs2_busy}, {31'd0, exp_busy});
        check({name, ".rs1_value"}, rs1_value, exp_val);
        check({name, ".rs2_value"}, rs2_value, exp_val);
        if (exp_tag >= 0) begin
            check({name, ".rs1_tag"}, {28'd0, rs1_tag}, 32'(exp_tag));
            check({name, ".rs2_tag"}, {28'd0, rs2_tag}, 32'(exp_tag));
        end
    endtask

    // Let one rising edge apply the driven controls, then idle them
    task automatic do_cycle();
        @(posedge clk);
        #1;
        issue_en  = 1'b0;
        commit_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [3:0] tag);
        issue_en  = 1'b1;
        issue_rd  = rd;
        issue_tag = tag;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [3:0] tag, input logic [31:0] val);
        commit_en    = 1'b1;
        commit_rd    = rd;
        commit_tag   = tag;
        commit_value = val;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        rdy          = 1'b1;
        issue_en     = 1'b0;
        issue_rd     = '0;
        issue_tag    = '0;
        rs1_index    = '0;
        rs2_index    = '0;
        commit_en    = 1'b0;
        commit_rd    = '0;
        commit_tag   = '0;
        commit_value = '0;
        flush        = 1'b0;

        // Reset asserted before any clock edge: every register reads zero
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) begin
            read_reg("reset", 5'(i), 1'b0, 0, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        do_cycle();

        // Rename then commit with bypass
        set_issue(5'd5, 4'd3);
        do_cycle();
        read_reg("ren5", 5'd5, 1'b1, 3, 32'h0);
        set_commit(5'd5, 4'd3, 32'hDEADBEEF);
        read_reg("byp5", 5'd5, 1'b0, -1, 32'hDEADBEEF);
        do_cycle();
        read_reg("com5", 5'd5, 1'b0, -1, 32'hDEADBEEF);

        // Stale commit keeps the younger rename pending
        set_issue(5'd7, 4'd2);
        do_cycle();
        set_issue(5'd7, 4'd6);
        do_cycle();
        set_commit(5'd7, 4'd2, 32'h11);
        read_reg("stale_byp7", 5'd7, 1'b1, 6, 32'h0);
        do_cycle();
        read_reg("stale7", 5'd7, 1'b1, 6, 32'h11);
        set_commit(5'd7, 4'd6, 32'h22);
        read_reg("fresh_byp7", 5'd7, 1'b0, -1, 32'h22);
        do_cycle();
        read_reg("fresh7", 5'd7, 1'b0, -1, 32'h22);

        // Issue and commit to the same register in one cycle
        set_issue(5'd9, 4'd1);
        do_cycle();
        set_commit(5'd9, 4'd1, 32'h55);
        set_issue(5'd9, 4'd4);
        read_reg("simul_byp9", 5'd9, 1'b0, -1, 32'h55);
        do_cycle();
        read_reg("simul9", 5'd9, 1'b1, 4, 32'h55);

        // Flush with a concurrent commit and a dropped issue
        set_issue(5'd1, 4'd7);
        do_cycle();
        set_issue(5'd2, 4'd8);
        do_cycle();
        set_issue(5'd3, 4'd9);
        do_cycle();
        flush = 1'b1;
        set_commit(5'd2, 4'd8, 32'h77);
        set_issue(5'd4, 4'd5);
        do_cycle();
        read_reg("flush1", 5'd1, 1'b0, -1, 32'h0);
        read_reg("flush2", 5'd2, 1'b0, -1, 32'h77);
        read_reg("flush3", 5'd3, 1'b0, -1, 32'h0);
        read_reg("flush4", 5'd4, 1'b0, 0, 32'h0);
        read_reg("flush9", 5'd9, 1'b0, -1, 32'h55);

        // x0 ignores issue and commit
        set_issue(5'd0, 4'd3);
        set_commit(5'd0, 4'd0, 32'h99);
        read_reg("x0_byp", 5'd0, 1'b0, 0, 32'h0);
        do_cycle();
        read_reg("x0", 5'd0, 1'b0, 0, 32'h0);

        // rdy low freezes state
        rdy = 1'b0;
        set_issue(5'd8, 4'd1);
        set_commit(5'd6, 4'd0, 32'hAB);
        do_cycle();
        rdy = 1'b1;
        read_reg("rdy_x8", 5'd8, 1'b0, 0, 32'h0);
        read_reg("rdy_x6", 5'd6, 1'b0, 0, 32'h0);

        // Bypass stays live while rdy is low, but the commit is not stored
        set_issue(5'd10, 4'd2);
        do_cycle();
        rdy = 1'b0;
        set_commit(5'd10, 4'd2, 32'h33);
        read_reg("rdy_byp10", 5'd10, 1'b0, -1, 32'h33);
        do_cycle();
        read_reg("rdy_hold10", 5'd10, 1'b1, 2, 32'h0);
        rdy = 1'b1;

        // Mid-operation asynchronous reset, checked before any clock edge
        set_issue(5'd11, 4'd5);
        do_cycle();
        read_reg("pre_rst11", 5'd11, 1'b1, 5, 32'h0);
        rst = 1'b1;
        #1;
        read_reg("arst11", 5'd11, 1'b0, 0, 32'h0);
        read_reg("arst9", 5'd9, 1'b0, 0, 32'h0);
        read_reg("arst7", 5'd7, 1'b0, 0, 32'h0);
        read_reg("arst10", 5'd10, 1'b0, 0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile
`default_nettype wire
